mdu_hilo: RTL and testbench

Iterative multiply/divide unit owning the architectural HI/LO registers. Sits in the execute stage directly downstream of the register file, consuming its two read operands (src1, src2) for MULT/MULTU/DIV/DIVU/MTHI/MTLO. It exposes HI/LO to the execute datapath for MFHI/MFLO. A valid/ready handshake stalls issue while a long operation is in flight.

---
 rtl/mdu_hilo_pkg.sv | 42 ++++
 rtl/mdu_divider.sv | 79 +++++++
 rtl/mdu_hilo.sv | 225 ++++++++++++++++++++++
 tb/tb_mdu_hilo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Contents: mdu_op_t issue opcodes, mdu_state_t FSM states, mdu_ctx_t
// per-operation context latched at accept, and a magnitude helper.
package mdu_hilo_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned MDU_ITER_CYCLES = 32;
  localparam int unsigned CNT_W           = 6;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  // Context captured at accept; src1 is kept raw for the divide-by-zero HI value.
  typedef struct packed {
    logic            is_mul;
    logic            neg_res;   // product / quotient must be negated
    logic            neg_rem;   // remainder takes the dividend sign
    logic            div_zero;
    logic [XLEN-1:0] src1;
  } mdu_ctx_t;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x,
                                          input logic            is_signed);
    return (is_signed && x[XLEN-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider core, one quotient bit per cycle.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   start            load unsigned dividend/divisor and begin 32 iterations
//   abort            drop any in-flight divide
//   dividend/divisor unsigned operands
//   busy             iterations in progress
//   result           {remainder, quotient}
module mdu_divider
  import mdu_hilo_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [XLEN-1:0]   dividend,
  input  logic [XLEN-1:0]   divisor,
  output logic              busy,
  output logic [2*XLEN-1:0] result
);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quot_q, quot_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;

  logic [XLEN:0]    shift_c;
  logic [XLEN-1:0]  diff_c;
  logic             ge_c;

  // Partial remainder shifted left with the next dividend bit.
  assign shift_c = {rem_q, quot_q[XLEN-1]};
  assign ge_c    = (shift_c >= {1'b0, dvs_q});
  // Only used when ge_c holds, where the true difference fits in XLEN bits.
  assign diff_c  = shift_c[XLEN-1:0] - dvs_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    dvs_d  = dvs_q;
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quot_d = dividend;
      dvs_d  = divisor;
    end else if (busy_q) begin
      rem_d  = ge_c ? diff_c : shift_c[XLEN-1:0];
      quot_d = {quot_q[XLEN-2:0], ge_c};
      cnt_d  = CNT_W'(cnt_q + 1'b1);
      if (cnt_q == CNT_W'(MDU_ITER_CYCLES - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy   = busy_q;
  assign result = {rem_q, quot_q};

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit owning architectural HI/LO.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   valid/ready        issue handshake (ready while idle)
//   op, src1, src2     operation and register-file operands
//   flush              squash any in-flight operation / drop an idle request
//   done               one-cycle pulse after HI/LO take a mult/div result
//   hi, lo             architectural HI and LO
// Configuration: MDU_FAST_MUL_EN selects a 2-stage pipelined multiplier
// (latency 3); otherwise MULT/MULTU run 32-step shift-add (latency 34).
module mdu_hilo
  import mdu_hilo_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid,
  output logic            ready,
  input  mdu_op_t         op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic             done_q, done_d;
  mdu_ctx_t         ctx_q, ctx_d;

  logic             accept_c;
  logic             is_signed_c;
  logic             is_mul_c;
  logic             is_div_c;
  logic [XLEN-1:0]  a_mag_c;
  logic [XLEN-1:0]  b_mag_c;

  logic             div_busy;
  logic [2*XLEN-1:0] div_result;
  logic [XLEN-1:0]  quot_c;
  logic [XLEN-1:0]  rem_c;

  logic [2*XLEN-1:0] prod_q;

  assign ready       = (state_q == ST_IDLE);
  assign accept_c    = valid && ready && !flush && (op != MDU_NOP);
  assign is_signed_c = (op == MDU_MULT) || (op == MDU_DIV);
  assign is_mul_c    = (op == MDU_MULT) || (op == MDU_MULTU);
  assign is_div_c    = (op == MDU_DIV)  || (op == MDU_DIVU);
  assign a_mag_c     = mag(src1, is_signed_c);
  assign b_mag_c     = mag(src2, is_signed_c);

  // Context latched at accept for sign fix-up and divide-by-zero handling.
  always_comb begin
    ctx_d          = ctx_q;
    ctx_d.is_mul   = is_mul_c;
    ctx_d.neg_res  = is_signed_c && (src1[XLEN-1] ^ src2[XLEN-1]);
    ctx_d.neg_rem  = is_signed_c && src1[XLEN-1];
    ctx_d.div_zero = (src2 == '0);
    ctx_d.src1     = src1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctx_q <= '0;
    end else if (accept_c) begin
      ctx_q <= ctx_d;
    end
  end

  mdu_divider u_divider (
    .clk      (clk),
    .resetn   (resetn),
    .start    (accept_c && is_div_c),
    .abort    (flush),
    .dividend (a_mag_c),
    .divisor  (b_mag_c),
    .busy     (div_busy),
    .result   (div_result)
  );

  assign quot_c = div_result[XLEN-1:0];
  assign rem_c  = div_result[2*XLEN-1:XLEN];

`ifdef MDU_FAST_MUL_EN
  // Stage 1 holds sign/zero-extended operands; stage 2 holds the product.
  // 64-bit operands make the low 64 bits of the 33x33 signed product exact.
  logic [2*XLEN-1:0] opa_q, opb_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      opa_q  <= '0;
      opb_q  <= '0;
      prod_q <= '0;
    end else begin
      if (accept_c && is_mul_c) begin
        opa_q <= {{XLEN{is_signed_c & src1[XLEN-1]}}, src1};
        opb_q <= {{XLEN{is_signed_c & src2[XLEN-1]}}, src2};
      end
      if (state_q == ST_MUL && cnt_q == '0) begin
        prod_q <= opa_q * opb_q;
      end
    end
  end
`else
  // Shift-add on magnitudes: prod_q starts as {0, multiplier} and shifts right.
  logic [XLEN-1:0]   mcand_q;
  logic [XLEN:0]     add_c;
  logic [2*XLEN-1:0] prod_d;

  assign add_c  = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                  (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
  assign prod_d = {add_c, prod_q[XLEN-1:1]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (accept_c && is_mul_c) begin
      mcand_q <= a_mag_c;
      prod_q  <= {{XLEN{1'b0}}, b_mag_c};
    end else if (state_q == ST_MUL) begin
      prod_q  <= prod_d;
    end
  end
`endif

  // Next-state, counter and HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          cnt_d = '0;
          case (op)
            MDU_MTHI:            hi_d    = src1;
            MDU_MTLO:            lo_d    = src1;
            MDU_MULT, MDU_MULTU: state_d = ST_MUL;
            MDU_DIV, MDU_DIVU:   state_d = ST_DIV;
            default:             state_d = ST_IDLE;
          endcase
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
`ifdef MDU_FAST_MUL_EN
        end else if (cnt_q == CNT_W'(1)) begin
          {hi_d, lo_d} = prod_q;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
          cnt_d        = '0;
`else
        end else if (cnt_q == CNT_W'(MDU_ITER_CYCLES - 1)) begin
          state_d = ST_FIX;
          cnt_d   = '0;
`endif
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      ST_DIV: begin
        // The divider's busy drop is a backstop in case the counters disagree.
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MDU_ITER_CYCLES - 1) || !div_busy) begin
          state_d = ST_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (!flush) begin
          done_d = 1'b1;
`ifndef MDU_FAST_MUL_EN
          if (ctx_q.is_mul) begin
            {hi_d, lo_d} = ctx_q.neg_res ? -prod_q : prod_q;
          end else
`endif
          if (ctx_q.div_zero) begin
            lo_d = '1;
            hi_d = ctx_q.src1;
          end else begin
            lo_d = ctx_q.neg_res ? -quot_c : quot_c;
            hi_d = ctx_q.neg_rem ? -rem_c  : rem_c;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed vectors push expected HI/LO and
// latency into a scoreboard; a monitor pops and compares on every done pulse.
module tb_mdu_hilo;
  import mdu_hilo_pkg::*;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        valid  = 1'b0;
  logic        flush  = 1'b0;
  mdu_op_t     op     = MDU_NOP;
  logic [31:0] src1   = '0;
  logic [31:0] src2   = '0;
  logic        ready;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mdu_hilo dut (
    .clk    (clk),
    .resetn (resetn),
    .valid  (valid),
    .ready  (ready),
    .op     (op),
    .src1   (src1),
    .src2   (src2),
    .flush  (flush),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

`ifdef MDU_FAST_MUL_EN
  localparam int unsigned MUL_LAT = 3;
`else
  localparam int unsigned MUL_LAT = 34;
`endif
  localparam int unsigned DIV_LAT = 34;

  typedef struct {
    int          id;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned c0;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          rdy_bad;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (resetn === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected 0", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("op%0d_hi", mon_e.id), hi, mon_e.hi);
        chk($sformatf("op%0d_lo", mon_e.id), lo, mon_e.lo);
        chk($sformatf("op%0d_latency", mon_e.id), 32'(cyc - mon_e.c0), 32'(mon_e.lat));
      end
    end
  end

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
  task automatic issue(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] eh, input logic [31:0] el,
                       input int unsigned lat, input int id);
    chk($sformatf("op%0d_ready_at_issue", id), 32'(ready), 32'd1);
    valid = 1'b1;
    op    = o;
    src1  = a;
    src2  = b;
    if (push) sb.push_back('{id, eh, el, cyc, lat});
    @(negedge clk);
    valid = 1'b0;
    op    = MDU_NOP;
    src1  = '0;
    src2  = '0;
  endtask

  task automatic wait_done(input int id);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_op%0d: %0d result(s) pending, expected 0", id, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done",  32'(done),  32'd0);
    chk("reset_hi",    hi,         32'd0);
    chk("reset_lo",    lo,         32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // DIVU 100/7: busy through cycle 33, result in cycle 34.
    issue(MDU_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, DIV_LAT, 1);
    rdy_bad = 0;
    for (int n = 1; n <= 33; n++) begin
      if (ready !== 1'b0) rdy_bad++;
      if (n < 33) @(negedge clk);
    end
    chk("divu_ready_low_cycles_1_33", 32'(rdy_bad), 32'd0);
    wait_done(1);
    chk("ready_after_divu", 32'(ready), 32'd1);

    issue(MDU_DIV,   32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT, 2);
    wait_done(2);
    issue(MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000, DIV_LAT, 3);
    wait_done(3);
    issue(MDU_DIV,   32'd7,        32'hFFFFFFFE, 1'b1, 32'h00000001, 32'hFFFFFFFD, DIV_LAT, 4);
    wait_done(4);
    issue(MDU_MULT,  32'hFFFFFFFF, 32'd2,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, 5);
    wait_done(5);
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2,        1'b1, 32'h00000001, 32'hFFFFFFFE, MUL_LAT, 6);
    wait_done(6);
    issue(MDU_MULT,  32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, MUL_LAT, 7);
    wait_done(7);
    issue(MDU_DIVU,  32'd5,        32'd0,        1'b1, 32'd5,        32'hFFFFFFFF, DIV_LAT, 8);
    wait_done(8);
    issue(MDU_DIV,   32'd5,        32'd0,        1'b1, 32'd5,        32'hFFFFFFFF, DIV_LAT, 9);
    wait_done(9);

    // MTHI/MTLO visible in cycle 1, unit stays ready.
    issue(MDU_MTHI, 32'h1234, 32'd0, 1'b0, 32'd0, 32'd0, 0, 10);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_ready", 32'(ready), 32'd1);
    issue(MDU_MTLO, 32'h5678, 32'd0, 1'b0, 32'd0, 32'd0, 0, 11);
    chk("mtlo_lo", lo, 32'h5678);
    chk("mtlo_hi_kept", hi, 32'h1234);

    // DIV flushed in cycle 10; MULTU issued in cycle 11.
    issue(MDU_DIV, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 0, 12);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", 32'(ready), 32'd1);
    chk("flush_hi",    hi,         32'h1234);
    chk("flush_lo",    lo,         32'h5678);
    issue(MDU_MULTU, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, MUL_LAT, 13);
    wait_done(13);

    // Flush with valid in IDLE drops even MTHI.
    valid = 1'b1;
    op    = MDU_MTHI;
    src1  = 32'hDEAD;
    flush = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    op    = MDU_NOP;
    src1  = '0;
    flush = 1'b0;
    chk("idle_flush_hi", hi, 32'd0);
    chk("idle_flush_lo", lo, 32'd12);

    // Reset in cycle 20 of a DIV discards it.
    issue(MDU_DIV, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 0, 14);
    repeat (19) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("midreset_hi",    hi,         32'd0);
    chk("midreset_lo",    lo,         32'd0);
    chk("midreset_ready", 32'(ready), 32'd1);
    chk("midreset_done",  32'(done),  32'd0);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_lo", lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
